control_unit: RTL and testbench

- Hardwired Moore control sequencer for the datapath; drives every datapath control strobe.
- Fetches each instruction (T0–T2), decodes IR[31:27], then steps through the execute micro-sequence for that instruction class.
- Register selection uses select-and-encode outputs (Gra/Grb/Grc, Rin/Rout/BAout), not per-register enables.

---
 rtl/control_unit.sv | 132 +++++++++++++
 tb/tb_control_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch (T0-T2), decode IR[31:27], then per-class
// execute steps. Outputs are decoded from the state register and IR only.
module control_unit #(
    parameter logic [4:0] INC_OP = 5'd12,
    parameter logic [4:0] ADD_OP = 5'd3
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  OpCode,
    output logic        Run
);

    localparam logic [3:0] S_RST = 4'd0;
    localparam logic [3:0] T0    = 4'd1;
    localparam logic [3:0] T1    = 4'd2;
    localparam logic [3:0] T2    = 4'd3;
    localparam logic [3:0] T3    = 4'd4;
    localparam logic [3:0] T4    = 4'd5;
    localparam logic [3:0] T5    = 4'd6;
    localparam logic [3:0] T6    = 4'd7;
    localparam logic [3:0] T7    = 4'd8;
    localparam logic [3:0] HALT  = 4'd9;

    logic [3:0] state, next_state;
    logic [4:0] op, imm_op;
    logic       is_alu, is_imm, is_un, is_ldi, is_ld, is_st, is_mem, is_halt, is_exec;
    logic       unused_ir;

    assign unused_ir = ^IR[26:0];
    assign op        = IR[31:27];
    assign is_alu    = op inside {[5'd3:5'd11]};
    assign is_imm    = op inside {[5'd12:5'd14]};
    assign is_un     = (op == 5'd17) || (op == 5'd18);
    assign is_ldi    = (op == 5'd1);
    assign is_ld     = (op == 5'd0);
    assign is_st     = (op == 5'd2);
    assign is_mem    = is_ld || is_st;
    assign is_halt   = (op == 5'd27);
    assign is_exec   = is_alu || is_imm || is_un || is_ldi || is_mem;

    // Immediate forms reuse the register-form ALU codes
    always_comb begin
        case (op)
            5'd12:   imm_op = 5'd3;
            5'd13:   imm_op = 5'd5;
            default: imm_op = 5'd6;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RST: next_state = T0;
            T0:    next_state = T1;
            T1:    next_state = T2;
            T2: begin
                if (is_halt)      next_state = HALT;
                else if (is_exec) next_state = T3;
                else              next_state = Stop ? HALT : T0;
            end
            T3:    next_state = T4;
            T4:    next_state = is_un ? (Stop ? HALT : T0) : T5;
            T5:    next_state = is_mem ? T6 : (Stop ? HALT : T0);
            T6:    next_state = T7;
            T7:    next_state = Stop ? HALT : T0;
            HALT:  next_state = HALT;
            default: next_state = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state <= S_RST;
        else     state <= next_state;
    end

    always_comb begin
        {PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout} = '0;
        {Read, Write, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
        OpCode = 5'd0;
        Run    = (state >= T0) && (state <= T7);
        case (state)
            T0: begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; OpCode = INC_OP; end
            T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                if (is_alu || is_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                else if (is_un) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; OpCode = op; end
                else if (is_ldi || is_mem) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            end
            T4: begin
                if (is_alu) begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; OpCode = op; end
                else if (is_imm) begin Cout = 1'b1; Zin = 1'b1; OpCode = imm_op; end
                else if (is_un) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_ldi || is_mem) begin Cout = 1'b1; Zin = 1'b1; OpCode = ADD_OP; end
            end
            T5: begin
                if (is_mem) begin Zlowout = 1'b1; MARin = 1'b1; end
                else if (is_alu || is_imm || is_ldi) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            T6: begin
                if (is_ld) begin Read = 1'b1; MDRin = 1'b1; end
                else if (is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            end
            T7: begin
                if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_st) Write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a step-table model of each instruction's micro-sequence
// predicts every output on every cycle under randomized IR/Stop stimulus.
module tb_control_unit;

    logic        clk, clr, Stop;
    logic [31:0] IR;
    logic PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Run;
    logic [4:0]  OpCode;
    logic [23:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .Stop(Stop),
        .PCout(PCout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
        .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .BAout(BAout), .OpCode(OpCode), .Run(Run)
    );

    assign obs = {PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout,
                  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Run, OpCode};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [23:0] PCOUT = 24'h800000, PCIN = 24'h400000, MARIN = 24'h200000;
    localparam logic [23:0] MDRIN = 24'h100000, MDROUT = 24'h080000, IRIN = 24'h040000;
    localparam logic [23:0] YIN = 24'h020000, ZIN = 24'h010000, ZLOW = 24'h008000;
    localparam logic [23:0] COUT = 24'h004000, READ = 24'h002000, WRITE = 24'h001000;
    localparam logic [23:0] GRA = 24'h000800, GRB = 24'h000400, GRC = 24'h000200;
    localparam logic [23:0] RIN = 24'h000100, ROUT = 24'h000080, BAOUT = 24'h000040;
    localparam logic [23:0] RUN = 24'h000020;

    localparam int M_RST = 0, M_RUN = 1, M_HALT = 2;

    // Model: current instruction as a list of step vectors plus an index into it
    logic [23:0] m_seq[$];
    int          m_idx  = 0;
    int          m_mode = M_RST;

    function automatic logic [23:0] opv(input logic [4:0] o);
        return {19'd0, o};
    endfunction

    function automatic void m_fetch();
        m_seq.delete();
        m_seq.push_back(RUN | PCOUT | MARIN | ZIN | opv(5'd12));
        m_seq.push_back(RUN | ZLOW | PCIN | READ | MDRIN);
        m_seq.push_back(RUN | MDROUT | IRIN);
        m_idx = 0;
    endfunction

    function automatic void m_exec(input logic [4:0] o);
        if (o >= 5'd3 && o <= 5'd11) begin
            m_seq.push_back(RUN | GRB | ROUT | YIN);
            m_seq.push_back(RUN | GRC | ROUT | ZIN | opv(o));
            m_seq.push_back(RUN | ZLOW | GRA | RIN);
        end else if (o >= 5'd12 && o <= 5'd14) begin
            m_seq.push_back(RUN | GRB | ROUT | YIN);
            m_seq.push_back(RUN | COUT | ZIN | opv(o == 5'd12 ? 5'd3 : (o == 5'd13 ? 5'd5 : 5'd6)));
            m_seq.push_back(RUN | ZLOW | GRA | RIN);
        end else if (o == 5'd17 || o == 5'd18) begin
            m_seq.push_back(RUN | GRB | ROUT | ZIN | opv(o));
            m_seq.push_back(RUN | ZLOW | GRA | RIN);
        end else if (o <= 5'd2) begin
            m_seq.push_back(RUN | GRB | BAOUT | YIN);
            m_seq.push_back(RUN | COUT | ZIN | opv(5'd3));
            if (o == 5'd1) m_seq.push_back(RUN | ZLOW | GRA | RIN);
            else           m_seq.push_back(RUN | ZLOW | MARIN);
            if (o == 5'd0) begin
                m_seq.push_back(RUN | READ | MDRIN);
                m_seq.push_back(RUN | MDROUT | GRA | RIN);
            end else if (o == 5'd2) begin
                m_seq.push_back(RUN | GRA | ROUT | MDRIN);
                m_seq.push_back(RUN | WRITE);
            end
        end
    endfunction

    function automatic void m_advance(input logic c, input logic s, input logic [31:0] ir);
        if (c) m_mode = M_RST;
        else if (m_mode == M_RST) begin m_mode = M_RUN; m_fetch(); end
        else if (m_mode == M_RUN) begin
            if (m_idx == 2) begin
                if (ir[31:27] == 5'd27) m_mode = M_HALT;
                else begin
                    m_exec(ir[31:27]);
                    if (m_seq.size() == 3) begin
                        if (s) m_mode = M_HALT; else m_fetch();
                    end else m_idx = 3;
                end
            end else if (m_idx == m_seq.size() - 1) begin
                if (s) m_mode = M_HALT; else m_fetch();
            end else m_idx++;
        end
    endfunction

    function automatic logic [23:0] m_exp();
        return (m_mode == M_RUN) ? m_seq[m_idx] : 24'd0;
    endfunction

    function automatic bit has_exec(input logic [4:0] o);
        return (o <= 5'd14) || o == 5'd17 || o == 5'd18 || o == 5'd27;
    endfunction

    task automatic tick(input logic c, input logic s, input logic [31:0] ir);
        clr = c; Stop = s; IR = ir;
        @(posedge clk);
        m_advance(c, s, ir);
        #1;
    endtask

    // Runs one instruction from T0; Stop is random on non-final steps
    task automatic run_instr(input logic [31:0] ir, input bit stop_last, input bit stop_mid,
                             output int cycles);
        logic [31:0] drv;
        logic        last, s;
        cycles = 0;
        do begin
            drv  = (m_idx < 2) ? $urandom : ir;
            last = (m_idx == 2) ? !has_exec(ir[31:27])
                                : (m_idx >= 3 && m_idx == m_seq.size() - 1);
            s    = last ? stop_last : (stop_mid ? 1'b1 : 1'($urandom));
            tick(1'b0, s, drv);
            cycles++;
            n_tests++;
            if (obs !== m_exp()) begin
                n_fail++;
                $display("FAIL step ir=%h cyc=%0d got=%h want=%h", ir, cycles, obs, m_exp());
            end
        end while (m_mode == M_RUN && m_idx != 0 && cycles < 20);
        if (cycles >= 20) begin
            n_fail++;
            $display("FAIL instr_timeout ir=%h got=%0d cycles want<20", ir, cycles);
        end
    endtask

    task automatic recover();
        tick(1'b1, 1'b0, $urandom);
        tick(1'b0, 1'b0, $urandom);
        n_tests++;
        if (obs !== (RUN | PCOUT | MARIN | ZIN | opv(5'd12))) begin
            n_fail++;
            $display("FAIL recover_t0 got=%h want=%h", obs, RUN | PCOUT | MARIN | ZIN | opv(5'd12));
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'($urandom), $urandom);
            n_tests++;
            if (obs !== 24'd0) begin
                n_fail++;
                $display("FAIL reset_outputs got=%h want=%h", obs, 24'd0);
            end
        end
        tick(1'b0, 1'b0, $urandom);
        n_tests++;
        if (obs !== (RUN | PCOUT | MARIN | ZIN | opv(5'd12))) begin
            n_fail++;
            $display("FAIL reset_to_t0 got=%h want=%h", obs, RUN | PCOUT | MARIN | ZIN | opv(5'd12));
        end
    endtask

    task automatic test_directed();
        logic [31:0] irs[4]  = '{32'h28918000, 32'h00800055, 32'h10800087, 32'h78000000};
        int          want[4] = '{6, 8, 8, 3};
        int          cyc;
        for (int i = 0; i < 4; i++) begin
            run_instr(irs[i], 1'b0, 1'b0, cyc);
            n_tests++;
            if (cyc !== want[i]) begin
                n_fail++;
                $display("FAIL t0_to_t0 ir=%h got=%0d want=%0d", irs[i], cyc, want[i]);
            end
        end
    endtask

    task automatic test_halt();
        int cyc;
        run_instr(32'hD8000000, 1'b0, 1'b0, cyc);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'($urandom), $urandom);
            n_tests++;
            if (obs !== 24'd0) begin
                n_fail++;
                $display("FAIL halt_hold cyc=%0d got=%h want=%h", i, obs, 24'd0);
            end
        end
        recover();
    endtask

    task automatic test_stop();
        int cyc;
        run_instr(32'h60800007, 1'b1, 1'b1, cyc);
        n_tests++;
        if (cyc !== 6 || Run !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_addi got cyc=%0d run=%b want cyc=6 run=0", cyc, Run);
        end
        tick(1'b0, 1'b0, $urandom);
        n_tests++;
        if (obs !== 24'd0) begin
            n_fail++;
            $display("FAIL stop_held got=%h want=%h", obs, 24'd0);
        end
        recover();
    endtask

    task automatic test_clr_mid();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, (i < 2) ? $urandom : 32'h00800055);
        n_tests++;
        if (obs !== (RUN | COUT | ZIN | opv(5'd3))) begin
            n_fail++;
            $display("FAIL clr_mid_t4 got=%h want=%h", obs, RUN | COUT | ZIN | opv(5'd3));
        end
        tick(1'b1, 1'b0, 32'h00800055);
        n_tests++;
        if (obs !== 24'd0) begin
            n_fail++;
            $display("FAIL clr_mid_rst got=%h want=%h", obs, 24'd0);
        end
        tick(1'b0, 1'b0, $urandom);
    endtask

    task automatic test_random();
        logic [4:0]  pool[12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 5'd11, 5'd12,
                                  5'd13, 5'd14, 5'd17, 5'd18, 5'd26};
        logic [31:0] ir;
        int          cyc;
        for (int i = 0; i < 60; i++) begin
            ir = $urandom;
            if ($urandom_range(3) != 0) ir[31:27] = pool[$urandom_range(11)];
            run_instr(ir, ($urandom_range(7) == 0), 1'b0, cyc);
            if (m_mode != M_RUN) recover();
        end
    endtask

    initial begin
        clr = 1'b1; Stop = 1'b0; IR = '0;
        test_reset();
        test_directed();
        test_halt();
        test_stop();
        test_clr_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
